// File: rtl/armcore_pkg.sv
// Shared types for the 64-bit Arm core front end.
//   XLEN / INSTR_W : address and instruction widths
//   fetch_state_e  : fetch FSM states
//   fetch_entry_t  : one buffered instruction {instr, pc, fault}
package armcore_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic {
    RUN     = 1'b0,
    FAULTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               fault;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instruction entries.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   push, push_data      : write an entry (ignored when full without a pop)
//   pop                  : consume the head entry (ignored when empty)
//   flush                : discard all entries; wins over push and pop
//   head, head_valid     : current head entry (all zeros when empty)
//   count                : number of stored entries
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type entry_t = logic,
  parameter int  CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign head       = head_valid ? mem[rd_ptr] : entry_t'('0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads,
// buffers responses and hands them to decode over valid/ready.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : instruction memory read request
//   imem_rsp_valid/data/fault        : in-order read response (never stalled)
//   redirect_valid, redirect_pc      : branch/exception redirect
//   dec_valid/ready/instr/pc/fault   : instruction stream to decode
//   pc                               : next address to request
//
// state   | meaning
// RUN     | issuing requests while credits allow
// FAULTED | fetch fault seen; nothing issued until a redirect
module fetch_unit
  import armcore_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_fault,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic               dec_fault,
  output logic [XLEN-1:0]    pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             mis_pend;
  logic             accept;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             head_valid;

  // Every in-flight request owns a FIFO slot, so a kept response always fits.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign accept      = imem_req_valid && imem_req_ready;
  assign rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep    = imem_rsp_valid && (drop_cnt == '0);
  assign out_next    = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    if (!reset && (state == RUN) && !redirect_valid && !mis_pend &&
        (credit_used < (CNT_W + 1)'(FIFO_DEPTH))) begin
      imem_req_valid = 1'b1;
    end
    if (redirect_valid) begin
      state_next = RUN;
    end else if (mis_pend) begin
      state_next = FAULTED;
    end else if (rsp_keep && imem_rsp_fault) begin
      state_next = FAULTED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      mis_pend    <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= out_next;
        mis_pend <= (redirect_pc[1:0] != 2'b00);
      end else begin
        mis_pend <= 1'b0;
        if (accept) pc <= next_word(pc);
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - 1'b1;
        end else if (rsp_keep) begin
          resp_pc <= next_word(resp_pc);
          // Everything still in flight after a fault belongs to the dead path.
          if (imem_rsp_fault) drop_cnt <= out_next;
        end
      end
    end
  end

  // A pending misaligned redirect reports itself as a faulting entry; pc still
  // holds the redirect target because nothing is issued meanwhile.
  always_comb begin
    push       = rsp_keep;
    push_entry = '{instr: imem_rsp_fault ? '0 : imem_rsp_data,
                   pc:    resp_pc,
                   fault: imem_rsp_fault};
    if (mis_pend) begin
      push       = 1'b1;
      push_entry = '{instr: '0, pc: pc, fault: 1'b1};
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (dec_valid && dec_ready),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign imem_req_addr = pc;
  assign dec_valid     = head_valid;
  assign dec_instr     = head.instr;
  assign dec_pc        = head.pc;
  assign dec_fault     = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple in-order instruction memory
// model (configurable latency, returns addr ^ 0xA5A5, optional fault address).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_fault = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_fault;
  logic [63:0] pc;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  logic [63:0] fault_addr = '1;

  fetch_unit #(.RESET_PC(64'h1000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_fault (imem_rsp_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_fault      (dec_fault),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  // Memory model: at each negedge, present any response due at the coming
  // edge, then record a request that the coming edge will accept.
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  mreq_t mr;
  int    nidx = 0;

  always @(negedge clk) begin
    nidx = nidx + 1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_fault = 1'b0;
    if (reset) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && mq[0].due <= nidx) begin
        mr = mq.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mr.addr[31:0] ^ 32'hA5A5;
        imem_rsp_fault = (mr.addr == fault_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        mr.addr = imem_req_addr;
        mr.due  = nidx + mem_lat;
        mq.push_back(mr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of the first cycle with reset low.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_pc", pc, 64'h1000);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_fault", dec_fault, 0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    // Streaming with 1-cycle memory
    mem_lat = 1;
    fault_addr = '1;
    do_reset();
    dec_ready = 1'b1;
    @(negedge clk);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 64'h1000);
    chk("first_dec_valid", dec_valid, 0);
    cyc();
    @(negedge clk);
    chk("pc_after_accept", pc, 64'h1004);
    for (int i = 0; i < 6; i++) begin
      cyc();
      @(negedge clk);
      chk("stream_valid", dec_valid, 1);
      chk("stream_pc", dec_pc, 64'h1000 + 64'(4 * i));
      chk("stream_instr", dec_instr, 64'((32'h1000 + 32'(4 * i)) ^ 32'hA5A5));
    end

    // Decode back-pressure: buffer fills, requests stop, drains in order
    cyc();
    dec_ready = 1'b0;
    repeat (9) cyc();
    @(negedge clk);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_pc", pc, 64'h1028);
    chk("stall_dec_valid", dec_valid, 1);
    chk("stall_dec_pc", dec_pc, 64'h1018);
    cyc();
    dec_ready = 1'b1;
    @(negedge clk);
    chk("release_req_valid", imem_req_valid, 0);
    chk("release_dec_pc", dec_pc, 64'h1018);
    for (int i = 1; i < 6; i++) begin
      cyc();
      @(negedge clk);
      if (i == 1) begin
        chk("resume_req_valid", imem_req_valid, 1);
        chk("resume_req_addr", imem_req_addr, 64'h1028);
      end
      chk("drain_valid", dec_valid, 1);
      chk("drain_pc", dec_pc, 64'h1018 + 64'(4 * i));
    end

    // Redirect with two requests in flight on a 3-cycle memory
    mem_lat = 3;
    do_reset();
    dec_ready = 1'b1;
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    @(negedge clk);
    chk("redir_cycle_req_valid", imem_req_valid, 0);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_pc", pc, 64'h2000);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_no_stale0", dec_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("redir_no_stale", dec_valid, 0);
    end
    cyc();
    @(negedge clk);
    chk("redir_first_valid", dec_valid, 1);
    chk("redir_first_pc", dec_pc, 64'h2000);
    chk("redir_first_instr", dec_instr, 64'h85A5);
    cyc();
    @(negedge clk);
    chk("redir_second_pc", dec_pc, 64'h2004);

    // Fetch fault at 0x1008
    mem_lat = 1;
    fault_addr = 64'h1008;
    do_reset();
    dec_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("flt_pre0_pc", dec_pc, 64'h1000);
    cyc();
    @(negedge clk);
    chk("flt_pre1_pc", dec_pc, 64'h1004);
    cyc();
    @(negedge clk);
    chk("flt_valid", dec_valid, 1);
    chk("flt_fault", dec_fault, 1);
    chk("flt_pc", dec_pc, 64'h1008);
    chk("flt_instr", dec_instr, 0);
    chk("flt_req_valid", imem_req_valid, 0);
    cyc();
    @(negedge clk);
    chk("flt_dropped", dec_valid, 0);
    chk("flt_req_idle", imem_req_valid, 0);
    chk("flt_hold_pc", pc, 64'h1010);
    cyc();
    cyc();
    @(negedge clk);
    chk("flt_req_still_idle", imem_req_valid, 0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    fault_addr = '1;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flt_resume_valid", imem_req_valid, 1);
    chk("flt_resume_addr", imem_req_addr, 64'h3000);
    cyc();
    cyc();
    @(negedge clk);
    chk("flt_resume_dec_pc", dec_pc, 64'h3000);
    chk("flt_resume_instr", dec_instr, 64'h95A5);
    chk("flt_resume_fault", dec_fault, 0);

    // Misaligned redirect
    do_reset();
    dec_ready = 1'b1;
    cyc();
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2002;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_req_valid0", imem_req_valid, 0);
    chk("mis_flushed", dec_valid, 0);
    chk("mis_pc", pc, 64'h2002);
    cyc();
    @(negedge clk);
    chk("mis_valid", dec_valid, 1);
    chk("mis_fault", dec_fault, 1);
    chk("mis_dec_pc", dec_pc, 64'h2002);
    chk("mis_instr", dec_instr, 0);
    chk("mis_req_valid1", imem_req_valid, 0);
    cyc();
    @(negedge clk);
    chk("mis_single_entry", dec_valid, 0);
    chk("mis_req_valid2", imem_req_valid, 0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 64'h4000;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_resume_valid", imem_req_valid, 1);
    chk("mis_resume_addr", imem_req_addr, 64'h4000);

    // Reset with three buffered entries
    do_reset();
    cyc();
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    chk("mid_pre_valid", dec_valid, 1);
    chk("mid_pre_pc", dec_pc, 64'h1000);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_dec_valid", dec_valid, 0);
    chk("mid_pc", pc, 64'h1000);
    chk("mid_req_valid", imem_req_valid, 1);
    chk("mid_req_addr", imem_req_addr, 64'h1000);
    dec_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("mid_restart_pc", dec_pc, 64'h1000);
    chk("mid_restart_instr", dec_instr, 64'hB5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
